// File: rtl/axi_req_arbiter_pkg.sv
// axi_arb_pkg: FSM state types and the static AXI3 field values shared by
// the request arbiter and its write channel.
package axi_arb_pkg;

   typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

   localparam logic [3:0] ARID_INST      = 4'd0;
   localparam logic [3:0] ARID_DATA      = 4'd1;
   localparam logic [3:0] AXI_LEN        = 4'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_LOCK       = 2'b00;
   localparam logic [3:0] AXI_CACHE      = 4'd0;
   localparam logic [2:0] AXI_PROT       = 3'd0;
   localparam logic [3:0] AXI_WID        = 4'd1;

endpackage

// File: rtl/axi_req_arbiter_if.sv
// AXI3 master bus of the core. "master" is the arbiter side, "slave" the
// memory/interconnect side.
interface axi_req_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [3:0]          arid;
   logic [ADDR_W-1:0]   araddr;
   logic [3:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic [1:0]          arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;

   logic [3:0]          rid;
   logic [DATA_W-1:0]   rdata;
   logic                rvalid;
   logic                rready;

   logic [3:0]          awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [3:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic [1:0]          awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;

   logic [3:0]          wid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic                bvalid;
   logic                bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_wr_channel.sv
// axi_wr_channel: single-beat store engine. Raises AW and W together, retires
// each on its own ready, waits for B, then pulses resp one cycle later.
// busy/pend_addr feed the fetch RAW guard in the top.
module axi_wr_channel
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [1:0]          req_size,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [2:0]          awsize,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic                bvalid,
   output logic                bready,
   output logic                busy,
   output logic [ADDR_W-1:0]   pend_addr,
   output logic                resp
);

   w_state_t            w_state, w_next;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          size_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                aw_done, w_done;

   // write FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_next;
   end

   // next state and channel valids; AW and W retire independently
   always_comb begin
      w_next  = w_state;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      case (w_state)
         W_IDLE: if (start) w_next = W_AW;
         W_AW: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
            if ((aw_done | awready) & (w_done | wready)) w_next = W_B;
         end
         W_B: begin
            bready = 1'b1;
            if (bvalid) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // store payload latch, completion flags and the delayed response pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         resp    <= 1'b0;
      end else begin
         resp <= (w_state == W_B) & bvalid;
         if (w_state == W_IDLE && start) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (awvalid & awready) aw_done <= 1'b1;
            if (wvalid & wready)   w_done  <= 1'b1;
         end
      end
   end

   assign awaddr    = addr_q;
   assign awsize    = {1'b0, size_q};
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign busy      = (w_state != W_IDLE);
   assign pend_addr = addr_q;

endmodule

// File: rtl/axi_req_arbiter.sv
// axi_req_arbiter: shares one AXI3 master between instruction fetch and data
// memory. Reads go through the local read FSM, stores through axi_wr_channel.
// Optional macro AXI_ARB_RR_EN: round-robin read arbitration instead of
// fixed data-over-fetch priority.
module axi_req_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                inst_req_valid,
   output logic                inst_req_ready,
   input  logic [ADDR_W-1:0]   inst_req_addr,
   output logic                inst_resp_valid,
   output logic [DATA_W-1:0]   inst_resp_data,
   input  logic                data_req_valid,
   output logic                data_req_ready,
   input  logic                data_req_wr,
   input  logic [1:0]          data_req_size,
   input  logic [ADDR_W-1:0]   data_req_addr,
   input  logic [DATA_W-1:0]   data_req_wdata,
   input  logic [DATA_W/8-1:0] data_req_wstrb,
   output logic                data_resp_valid,
   output logic [DATA_W-1:0]   data_resp_rdata,
   axi_req_arbiter_if.master   axi
);

   r_state_t          r_state, r_next;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_src;            // 1 = data load, 0 = fetch
   logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;
   logic              inst_resp_q, data_rd_resp_q;
   logic              data_busy;        // one data transaction in flight
   logic              w_busy, w_resp;
   logic [ADDR_W-1:0] w_addr;
   logic              inst_ok, load_ok, grant_data, inst_acc, load_acc, store_acc;
`ifdef AXI_ARB_RR_EN
   logic              last_data;        // 1 = data won the last read grant
`endif

   // eligibility: a blocked requester never wins and never stalls the other
   always_comb begin
      inst_ok = inst_req_valid &
                ~(w_busy & (w_addr[ADDR_W-1:2] == inst_req_addr[ADDR_W-1:2]));
      load_ok = data_req_valid & ~data_req_wr & ~data_busy;
`ifdef AXI_ARB_RR_EN
      grant_data = load_ok & (~inst_ok | ~last_data);
`else
      grant_data = load_ok;
`endif
      store_acc = data_req_valid & data_req_wr & ~data_busy & ~reset;
   end

   // read FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_next;
   end

   // read FSM next state, accepts and AR/R handshake outputs
   always_comb begin
      r_next      = r_state;
      inst_acc    = 1'b0;
      load_acc    = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      case (r_state)
         R_IDLE: begin
            load_acc = grant_data & ~reset;
            inst_acc = inst_ok & ~grant_data & ~reset;
            if (load_acc | inst_acc) r_next = R_AR;
         end
         R_AR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) r_next = R_R;
         end
         R_R: begin
            axi.rready = 1'b1;
            if (axi.rvalid) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // read request latch, response capture and data-busy tracking
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr         <= '0;
         r_size         <= '0;
         r_src          <= 1'b0;
         inst_rdata_q   <= '0;
         data_rdata_q   <= '0;
         inst_resp_q    <= 1'b0;
         data_rd_resp_q <= 1'b0;
         data_busy      <= 1'b0;
      end else begin
         inst_resp_q    <= (r_state == R_R) & axi.rvalid & ~r_src;
         data_rd_resp_q <= (r_state == R_R) & axi.rvalid & r_src;
         if (load_acc) begin
            r_addr <= data_req_addr;
            r_size <= data_req_size;
            r_src  <= 1'b1;
         end else if (inst_acc) begin
            r_addr <= inst_req_addr;
            r_size <= 2'd2;
            r_src  <= 1'b0;
         end
         if (r_state == R_R && axi.rvalid) begin
            if (r_src) data_rdata_q <= axi.rdata;
            else       inst_rdata_q <= axi.rdata;
         end
         if (load_acc | store_acc)  data_busy <= 1'b1;
         else if (data_resp_valid)  data_busy <= 1'b0;
      end
   end

`ifdef AXI_ARB_RR_EN
   // last-grant memory for round-robin; starts as "fetch granted last"
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         last_data <= 1'b0;
      else if (load_acc) last_data <= 1'b1;
      else if (inst_acc) last_data <= 1'b0;
   end
`endif

   axi_wr_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
      .clock     (clock),
      .reset     (reset),
      .start     (store_acc),
      .req_addr  (data_req_addr),
      .req_size  (data_req_size),
      .req_wdata (data_req_wdata),
      .req_wstrb (data_req_wstrb),
      .awaddr    (axi.awaddr),
      .awsize    (axi.awsize),
      .awvalid   (axi.awvalid),
      .awready   (axi.awready),
      .wdata     (axi.wdata),
      .wstrb     (axi.wstrb),
      .wvalid    (axi.wvalid),
      .wready    (axi.wready),
      .bvalid    (axi.bvalid),
      .bready    (axi.bready),
      .busy      (w_busy),
      .pend_addr (w_addr),
      .resp      (w_resp)
   );

   assign inst_req_ready  = inst_acc;
   assign data_req_ready  = load_acc | store_acc;
   assign inst_resp_valid = inst_resp_q;
   assign inst_resp_data  = inst_rdata_q;
   // loads and stores never respond together; store completions read as 0
   assign data_resp_valid = data_rd_resp_q | w_resp;
   assign data_resp_rdata = data_rd_resp_q ? data_rdata_q : '0;

   assign axi.arid    = r_src ? ARID_DATA : ARID_INST;
   assign axi.araddr  = r_addr;
   assign axi.arsize  = {1'b0, r_size};
   assign axi.arlen   = AXI_LEN;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arlock  = AXI_LOCK;
   assign axi.arcache = AXI_CACHE;
   assign axi.arprot  = AXI_PROT;
   assign axi.awid    = AXI_WID;
   assign axi.awlen   = AXI_LEN;
   assign axi.awburst = AXI_BURST_INCR;
   assign axi.awlock  = AXI_LOCK;
   assign axi.awcache = AXI_CACHE;
   assign axi.awprot  = AXI_PROT;
   assign axi.wid     = AXI_WID;
   assign axi.wlast   = 1'b1;

endmodule
